// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//
// Shares one single-port SRAM macro (registered Do) between two requesters:
//   port 0 : AHB-lite SRAM slave path of the system bus
//   port 1 : DMA / auxiliary master
// At most one access is issued per cycle. On contention the winner is chosen
// round-robin (P0_PRIO=0) or by port-0 priority with a starvation limit
// (P0_PRIO=1). Read data returns one cycle after issue, straight from the
// macro's Do, so back-to-back accesses can be issued every cycle.
//
// Ports
//   HCLK, HRESETn          clock, synchronous active-low reset
//   reqN_valid/we/addr/wdata request from port N (we all-zero = read)
//   reqN_ready             combinational grant for port N
//   rspN_valid/rdata       one-cycle response pulse, rdata 0 for writes
//   SRAMWEN/CS0/ADDR/WDATA macro WE/EN/A/Di
//   SRAMRDATA              macro Do
//   contention             registered: both requests were valid last cycle
// -----------------------------------------------------------------------------
module sram_port_arbiter #(
   parameter int AW         = 10,
   parameter int DW         = 64,
   parameter bit P0_PRIO    = 1'b0,
   parameter int MAX_STREAK = 4
) (
   input  logic          HCLK,
   input  logic          HRESETn,
   // port 0
   input  logic          req0_valid,
   input  logic [DW/8-1:0] req0_we,
   input  logic [AW-1:0] req0_addr,
   input  logic [DW-1:0] req0_wdata,
   output logic          req0_ready,
   output logic          rsp0_valid,
   output logic [DW-1:0] rsp0_rdata,
   // port 1
   input  logic          req1_valid,
   input  logic [DW/8-1:0] req1_we,
   input  logic [AW-1:0] req1_addr,
   input  logic [DW-1:0] req1_wdata,
   output logic          req1_ready,
   output logic          rsp1_valid,
   output logic [DW-1:0] rsp1_rdata,
   // SRAM macro
   output logic [DW/8-1:0] SRAMWEN,
   output logic          SRAMCS0,
   output logic [AW-1:0] SRAMADDR,
   output logic [DW-1:0] SRAMWDATA,
   input  logic [DW-1:0] SRAMRDATA,
   // status
   output logic          contention
);

   localparam int        BW         = DW / 8;
   localparam int        NPORT      = 2;
   localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

   typedef struct packed {
      logic [BW-1:0] we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } req_t;

   // request view as arrays so the datapath mux is indexed by the grant
   logic [NPORT-1:0]          req_valid;
   req_t [NPORT-1:0]          req;
   logic [NPORT-1:0]          rsp_valid;
   logic [NPORT-1:0][DW-1:0]  rsp_rdata;

   assign req_valid = {req1_valid, req0_valid};
   assign req[0]    = '{we: req0_we, addr: req0_addr, wdata: req0_wdata};
   assign req[1]    = '{we: req1_we, addr: req1_addr, wdata: req1_wdata};

   // --------------------------------------------------------------------------
   // state
   // --------------------------------------------------------------------------
   logic       last_grant_q, last_grant_d;
   logic [3:0] streak_q,     streak_d;
   logic       pend_v_q,     pend_v_d;
   logic       pend_port_q,  pend_port_d;
   logic       pend_rd_q,    pend_rd_d;
   logic       contention_q, contention_d;

   // --------------------------------------------------------------------------
   // grant
   // --------------------------------------------------------------------------
   logic gnt_v;   // some port is granted this cycle
   logic gnt_p;   // which one

   always_comb begin
      gnt_v = 1'b0;
      gnt_p = 1'b0;
      if (req0_valid && req1_valid) begin
         gnt_v = 1'b1;
         if (P0_PRIO)
            // port 0 keeps winning until it has taken MAX_STREAK grants in a
            // row against a waiting port 1
            gnt_p = (streak_q == STREAK_MAX);
         else
            gnt_p = ~last_grant_q;
      end else if (req0_valid) begin
         gnt_v = 1'b1;
         gnt_p = 1'b0;
      end else if (req1_valid) begin
         gnt_v = 1'b1;
         gnt_p = 1'b1;
      end
   end

   assign req0_ready = gnt_v && (gnt_p == 1'b0);
   assign req1_ready = gnt_v && (gnt_p == 1'b1);

   // --------------------------------------------------------------------------
   // SRAM drive: granted port straight through, all-zero when idle
   // --------------------------------------------------------------------------
   always_comb begin
      SRAMCS0   = 1'b0;
      SRAMWEN   = '0;
      SRAMADDR  = '0;
      SRAMWDATA = '0;
      if (gnt_v) begin
         SRAMCS0   = 1'b1;
         SRAMWEN   = req[gnt_p].we;
         SRAMADDR  = req[gnt_p].addr;
         SRAMWDATA = req[gnt_p].wdata;
      end
   end

   // --------------------------------------------------------------------------
   // next state
   // --------------------------------------------------------------------------
   always_comb begin
      last_grant_d = last_grant_q;
      streak_d     = streak_q;
      pend_v_d     = gnt_v;
      pend_port_d  = pend_port_q;
      pend_rd_d    = pend_rd_q;
      contention_d = req0_valid && req1_valid;
      if (gnt_v) begin
         last_grant_d = gnt_p;
         pend_port_d  = gnt_p;
         pend_rd_d    = ~|req[gnt_p].we;
         // streak counts port-0 wins only while port 1 is actually waiting
         if (!gnt_p && req1_valid)
            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 4'd1;
         else
            streak_d = '0;
      end
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         last_grant_q <= 1'b1;   // so port 0 wins the first tie
         streak_q     <= '0;
         pend_v_q     <= 1'b0;   // any in-flight response is dropped
         pend_port_q  <= 1'b0;
         pend_rd_q    <= 1'b0;
         contention_q <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
         streak_q     <= streak_d;
         pend_v_q     <= pend_v_d;
         pend_port_q  <= pend_port_d;
         pend_rd_q    <= pend_rd_d;
         contention_q <= contention_d;
      end
   end

   assign contention = contention_q;

   // --------------------------------------------------------------------------
   // per-port response: rdata follows Do in the response cycle, otherwise
   // holds the last value delivered to that port
   // --------------------------------------------------------------------------
   for (genvar p = 0; p < NPORT; p++) begin : g_port
      logic          sel;
      logic [DW-1:0] rdata_d;
      logic [DW-1:0] rdata_q;

      assign sel          = pend_v_q && (pend_port_q == 1'(p));
      assign rdata_d      = pend_rd_q ? SRAMRDATA : '0;
      assign rsp_valid[p] = sel;
      assign rsp_rdata[p] = sel ? rdata_d : rdata_q;

      always_ff @(posedge HCLK) begin
         if (!HRESETn)
            rdata_q <= '0;
         else if (sel)
            rdata_q <= rdata_d;
      end
   end

   assign rsp0_valid = rsp_valid[0];
   assign rsp1_valid = rsp_valid[1];
   assign rsp0_rdata = rsp_rdata[0];
   assign rsp1_rdata = rsp_rdata[1];

endmodule
